alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; all values below assume WIDTH=8.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  WIDTH  operand A, value of register selected by Abus.
REQ-005 b  input  WIDTH  operand B, value of register selected by Bbus.
REQ-006 n  input  4  opcode, sampled every cycle.
REQ-007 cc  output  4  condition codes, registered: cc[0]=Z, cc[1]=N, cc[2]=C, cc[3]=V.
REQ-008 tr  output  WIDTH  registered result, written to the Rbus register by the datapath.
REQ-009 writeEnable  output  1  registered; 1 = tr is valid and shall be written to the Rbus register.

Function
REQ-010 Latency exactly 1 cycle: operands/opcode present before posedge k produce tr/cc/writeEnable after posedge k.
REQ-011 Opcodes (result R, writeEnable=1 unless stated): 0 ADD R=a+b; 1 SUB R=a-b; 2 AND; 3 OR; 4 XOR; 5 NOT R=~a; 6 SHL R=a<<1; 7 SHR R=a>>1 (logical); 8 LOAD; 9 MOV R=a; 10 INC R=a+1; 11 DEC R=a-1; 12 CMP; 13 ASR R={a[7],a[7:1]}; 14 ROL R={a[6:0],a[7]}; 15 NOP.
REQ-012 All arithmetic modulo 2^WIDTH; results wrap (0xFF+1=0x00, 0x00-1=0xFF).
REQ-013 LOAD (8): writeEnable=0, tr and cc hold; the datapath writes memory data itself.
REQ-014 CMP (12): computes flags of a-b, writeEnable=0, tr holds.
REQ-015 NOP (15): writeEnable=0, tr and cc hold.
REQ-016 Z=1 iff R==0; N=R[WIDTH-1]; for CMP, R is the discarded a-b.
REQ-017 C: ADD/INC carry-out; SUB/CMP/DEC borrow (1 iff a<b unsigned, or a==0 for DEC); SHL/ROL old a[7]; SHR/ASR old a[0]; logic, NOT, MOV C=0.
REQ-018 V: signed overflow for ADD/SUB/CMP/INC/DEC; 0 for all other writing opcodes.
REQ-019 writeEnable is a single-cycle strobe per issued op; repeated identical opcodes re-assert it every cycle.
REQ-020 Outputs depend only on registered state; no combinational path from inputs to outputs.
REQ-021 Inputs carrying X/unknown opcode values shall not be decoded; all 16 codes are defined, no default latch.

Reset
REQ-022 rst_n=0 asynchronously forces tr=0, cc=4'b0000, writeEnable=0 regardless of clk.
REQ-023 Reset mid-operation discards the pending result; first op after rst_n rises completes normally 1 cycle later.
REQ-024 Reset release is synchronised by design convention: first capture occurs on the first posedge with rst_n=1.

Configuration
REQ-025 Macro ALU_SHIFT_EXT_EN: defined, opcodes 13 (ASR) and 14 (ROL) operate per REQ-011/017.
REQ-026 ALU_SHIFT_EXT_EN undefined: opcodes 13 and 14 behave as NOP (writeEnable=0, tr/cc hold); all other opcodes unchanged.

Verification
REQ-027 Reset: rst_n=0 mid-cycle after ADD result 0x10 -> tr=0x00, cc=0000, writeEnable=0 immediately, no clk edge needed.
REQ-028 ADD a=0xFF b=0x01 n=0 -> next cycle tr=0x00, Z=1 N=0 C=1 V=0, writeEnable=1; ADD a=0x7F b=0x01 -> tr=0x80, N=1 V=1 C=0.
REQ-029 SUB a=0x03 b=0x05 n=1 -> tr=0xFE, N=1 C=1 Z=0 V=0; CMP a=0x05 b=0x05 n=12 -> Z=1, writeEnable=0, tr unchanged.
REQ-030 LOAD n=8 after ADD result 0x2A -> writeEnable=0, tr stays 0x2A, cc unchanged; then NOP n=15 -> same.
REQ-031 Shifts a=0x81: SHL -> tr=0x02 C=1; SHR -> tr=0x40 C=1; ASR -> 0xC0 (with macro) or NOP behaviour (without); ROL -> 0x03 (with macro).
REQ-032 Back-to-back: INC a=0xFF then DEC a=0x00 on consecutive cycles -> tr=0x00 Z=1 C=1, then tr=0xFF N=1 C=1, writeEnable high both cycles.

Source files
------------

// File: rtl/alu.sv
// Single-cycle registered ALU: 16 opcodes, Z/N/C/V condition codes, write strobe.
// Optional feature macro: ALU_SHIFT_EXT_EN enables ASR (13) and ROL (14);
// without it both opcodes behave as NOP.
module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       n,
    output logic [3:0]       cc,
    output logic [WIDTH-1:0] tr,
    output logic             writeEnable
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned EW  = WIDTH + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_MOV  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;
    localparam logic [3:0] OP_ASR  = 4'd13;
    localparam logic [3:0] OP_ROL  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    logic [EW-1:0]    sum_c;
    logic [EW-1:0]    diff_c;
    logic [EW-1:0]    inc_c;
    logic [EW-1:0]    dec_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             wr_c;
    logic             flags_c;
    logic [WIDTH-1:0] tr_next_c;
    logic [3:0]       cc_next_c;

    // Extended-width arithmetic so the top bit is carry-out / borrow.
    always_comb begin
        sum_c  = {1'b0, a} + {1'b0, b};
        diff_c = {1'b0, a} - {1'b0, b};
        inc_c  = {1'b0, a} + EW'(1);
        dec_c  = {1'b0, a} - EW'(1);
    end

    // Opcode decode: result, carry, overflow, and whether tr/cc get updated.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        wr_c    = 1'b0;
        flags_c = 1'b0;
        case (n)
            OP_ADD: begin
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (a[MSB] == b[MSB]) && (res_c[MSB] != a[MSB]);
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res_c   = diff_c[MSB:0];
                carry_c = diff_c[WIDTH];
                ovf_c   = (a[MSB] != b[MSB]) && (res_c[MSB] != a[MSB]);
                wr_c    = (n == OP_SUB);
                flags_c = 1'b1;
            end
            OP_AND: begin
                res_c   = a & b;
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_OR: begin
                res_c   = a | b;
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_XOR: begin
                res_c   = a ^ b;
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_NOT: begin
                res_c   = ~a;
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_SHL: begin
                res_c   = {a[MSB-1:0], 1'b0};
                carry_c = a[MSB];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_SHR: begin
                res_c   = {1'b0, a[MSB:1]};
                carry_c = a[0];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_MOV: begin
                res_c   = a;
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_INC: begin
                res_c   = inc_c[MSB:0];
                carry_c = inc_c[WIDTH];
                ovf_c   = !a[MSB] && res_c[MSB];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_DEC: begin
                res_c   = dec_c[MSB:0];
                carry_c = dec_c[WIDTH];
                ovf_c   = a[MSB] && !res_c[MSB];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
`ifdef ALU_SHIFT_EXT_EN
            OP_ASR: begin
                res_c   = {a[MSB], a[MSB:1]};
                carry_c = a[0];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
            OP_ROL: begin
                res_c   = {a[MSB-1:0], a[MSB]};
                carry_c = a[MSB];
                wr_c    = 1'b1;
                flags_c = 1'b1;
            end
`else
            OP_ASR, OP_ROL: begin
                wr_c    = 1'b0;
            end
`endif
            OP_LOAD, OP_NOP: begin
                wr_c    = 1'b0;
            end
            default: begin
                wr_c    = 1'b0;
            end
        endcase
    end

    // Next-state values: hold tr/cc unless the op updates them.
    always_comb begin
        tr_next_c = tr;
        cc_next_c = cc;
        if (wr_c) begin
            tr_next_c = res_c;
        end
        if (flags_c) begin
            cc_next_c = {ovf_c, carry_c, res_c[MSB], (res_c == '0)};
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr          <= '0;
            cc          <= 4'b0000;
            writeEnable <= 1'b0;
        end else begin
            tr          <= tr_next_c;
            cc          <= cc_next_c;
            writeEnable <= wr_c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=8).
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] n;
    logic [3:0] cc;
    logic [7:0] tr;
    logic       writeEnable;

    int checks;
    int fails;

    alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .n           (n),
        .cc          (cc),
        .tr          (tr),
        .writeEnable (writeEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one op at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        n = op;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 8'h00;
        b = 8'h00;
        n = 4'd15;
        #3;
        checks++;
        if ({tr, cc, writeEnable} !== {8'h00, 4'b0000, 1'b0}) begin
            fails++;
            $display("FAIL reset_initial: got tr=%h cc=%b we=%b, want tr=00 cc=0000 we=0", tr, cc, writeEnable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 8'h08, 8'h08);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h10, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL reset_add10: got tr=%h cc=%b we=%b, want tr=10 cc=0000 we=1", tr, cc, writeEnable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tr, cc, writeEnable} !== {8'h00, 4'b0000, 1'b0}) begin
            fails++;
            $display("FAIL reset_async: got tr=%h cc=%b we=%b, want tr=00 cc=0000 we=0", tr, cc, writeEnable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 8'h01, 8'h02);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h03, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL reset_first_op: got tr=%h cc=%b we=%b, want tr=03 cc=0000 we=1", tr, cc, writeEnable);
        end
    endtask

    task automatic test_add();
        step(4'd0, 8'hFF, 8'h01);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h00, 4'b0101, 1'b1}) begin
            fails++;
            $display("FAIL add_wrap: got tr=%h cc=%b we=%b, want tr=00 cc=0101 we=1", tr, cc, writeEnable);
        end
        step(4'd0, 8'h7F, 8'h01);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h80, 4'b1010, 1'b1}) begin
            fails++;
            $display("FAIL add_ovf: got tr=%h cc=%b we=%b, want tr=80 cc=1010 we=1", tr, cc, writeEnable);
        end
    endtask

    task automatic test_sub_cmp();
        step(4'd1, 8'h03, 8'h05);
        checks++;
        if ({tr, cc, writeEnable} !== {8'hFE, 4'b0110, 1'b1}) begin
            fails++;
            $display("FAIL sub_borrow: got tr=%h cc=%b we=%b, want tr=FE cc=0110 we=1", tr, cc, writeEnable);
        end
        step(4'd12, 8'h05, 8'h05);
        checks++;
        if ({tr, cc, writeEnable} !== {8'hFE, 4'b0001, 1'b0}) begin
            fails++;
            $display("FAIL cmp_equal: got tr=%h cc=%b we=%b, want tr=FE cc=0001 we=0", tr, cc, writeEnable);
        end
        step(4'd12, 8'h80, 8'h01);
        checks++;
        if ({tr, cc, writeEnable} !== {8'hFE, 4'b1000, 1'b0}) begin
            fails++;
            $display("FAIL cmp_ovf: got tr=%h cc=%b we=%b, want tr=FE cc=1000 we=0", tr, cc, writeEnable);
        end
    endtask

    task automatic test_load_nop();
        step(4'd0, 8'h9A, 8'h90);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h2A, 4'b1100, 1'b1}) begin
            fails++;
            $display("FAIL load_setup: got tr=%h cc=%b we=%b, want tr=2A cc=1100 we=1", tr, cc, writeEnable);
        end
        step(4'd8, 8'hFF, 8'hFF);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h2A, 4'b1100, 1'b0}) begin
            fails++;
            $display("FAIL load_hold: got tr=%h cc=%b we=%b, want tr=2A cc=1100 we=0", tr, cc, writeEnable);
        end
        step(4'd15, 8'h00, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h2A, 4'b1100, 1'b0}) begin
            fails++;
            $display("FAIL nop_hold: got tr=%h cc=%b we=%b, want tr=2A cc=1100 we=0", tr, cc, writeEnable);
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ops [5];
        logic [7:0]  av  [5];
        logic [7:0]  bv  [5];
        logic [12:0] exp [5];
        ops[0] = 4'd2; av[0] = 8'hF0; bv[0] = 8'h3C; exp[0] = {8'h30, 4'b0000, 1'b1};
        ops[1] = 4'd3; av[1] = 8'hF0; bv[1] = 8'h0F; exp[1] = {8'hFF, 4'b0010, 1'b1};
        ops[2] = 4'd4; av[2] = 8'hAA; bv[2] = 8'hAA; exp[2] = {8'h00, 4'b0001, 1'b1};
        ops[3] = 4'd5; av[3] = 8'h0F; bv[3] = 8'h00; exp[3] = {8'hF0, 4'b0010, 1'b1};
        ops[4] = 4'd9; av[4] = 8'h55; bv[4] = 8'hFF; exp[4] = {8'h55, 4'b0000, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(ops[i], av[i], bv[i]);
            checks++;
            if ({tr, cc, writeEnable} !== exp[i]) begin
                fails++;
                $display("FAIL logic_op%0d: got tr=%h cc=%b we=%b, want tr=%h cc=%b we=%b",
                         ops[i], tr, cc, writeEnable, exp[i][12:5], exp[i][4:1], exp[i][0]);
            end
        end
    endtask

    task automatic test_shift();
        step(4'd6, 8'h81, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h02, 4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL shl: got tr=%h cc=%b we=%b, want tr=02 cc=0100 we=1", tr, cc, writeEnable);
        end
        step(4'd7, 8'h81, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h40, 4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL shr: got tr=%h cc=%b we=%b, want tr=40 cc=0100 we=1", tr, cc, writeEnable);
        end
`ifdef ALU_SHIFT_EXT_EN
        step(4'd13, 8'h81, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'hC0, 4'b0110, 1'b1}) begin
            fails++;
            $display("FAIL asr: got tr=%h cc=%b we=%b, want tr=C0 cc=0110 we=1", tr, cc, writeEnable);
        end
        step(4'd14, 8'h81, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h03, 4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL rol: got tr=%h cc=%b we=%b, want tr=03 cc=0100 we=1", tr, cc, writeEnable);
        end
`else
        step(4'd13, 8'h81, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h40, 4'b0100, 1'b0}) begin
            fails++;
            $display("FAIL asr_off: got tr=%h cc=%b we=%b, want tr=40 cc=0100 we=0", tr, cc, writeEnable);
        end
        step(4'd14, 8'h01, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h40, 4'b0100, 1'b0}) begin
            fails++;
            $display("FAIL rol_off: got tr=%h cc=%b we=%b, want tr=40 cc=0100 we=0", tr, cc, writeEnable);
        end
`endif
    endtask

    task automatic test_back_to_back();
        step(4'd10, 8'hFF, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h00, 4'b0101, 1'b1}) begin
            fails++;
            $display("FAIL b2b_inc: got tr=%h cc=%b we=%b, want tr=00 cc=0101 we=1", tr, cc, writeEnable);
        end
        step(4'd11, 8'h00, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'hFF, 4'b0110, 1'b1}) begin
            fails++;
            $display("FAIL b2b_dec: got tr=%h cc=%b we=%b, want tr=FF cc=0110 we=1", tr, cc, writeEnable);
        end
        step(4'd10, 8'h7F, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h80, 4'b1010, 1'b1}) begin
            fails++;
            $display("FAIL inc_ovf: got tr=%h cc=%b we=%b, want tr=80 cc=1010 we=1", tr, cc, writeEnable);
        end
        step(4'd11, 8'h80, 8'h00);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h7F, 4'b1000, 1'b1}) begin
            fails++;
            $display("FAIL dec_ovf: got tr=%h cc=%b we=%b, want tr=7F cc=1000 we=1", tr, cc, writeEnable);
        end
        step(4'd0, 8'h01, 8'h01);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h02, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL repeat_add1: got tr=%h cc=%b we=%b, want tr=02 cc=0000 we=1", tr, cc, writeEnable);
        end
        step(4'd0, 8'h01, 8'h01);
        checks++;
        if ({tr, cc, writeEnable} !== {8'h02, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL repeat_add2: got tr=%h cc=%b we=%b, want tr=02 cc=0000 we=1", tr, cc, writeEnable);
        end
        step(4'd15, 8'h00, 8'h00);
        checks++;
        if (writeEnable !== 1'b0) begin
            fails++;
            $display("FAIL strobe_drop: got we=%b, want we=0", writeEnable);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_load_nop();
        test_logic();
        test_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
